// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: sequential prefetcher, in-flight PC FIFO and output queue.
// Optional misaligned-PC exception entry enabled by defining IFETCH_MISALIGN_EXC_EN.
module ifetch_prefetch #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  output logic        inst_uncached,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_except_type
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int QPW = $clog2(DEPTH);
  localparam int QCW = QPW + 1;
  localparam logic [31:0] EXC_ADEL = 32'h0000_4000;

`ifdef IFETCH_MISALIGN_EXC_EN
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif

  logic [31:0]    fetch_pc;
  logic [OW-1:0]  outstanding;
  logic [OW-1:0]  outstanding_next;
  logic [OW-1:0]  discard;
  logic           halted;

  logic [31:0]    pcf_mem [MAX_OUTSTANDING];
  logic [PW-1:0]  pcf_wr;
  logic [PW-1:0]  pcf_rd;

  logic [31:0]    q_pc   [DEPTH];
  logic [31:0]    q_inst [DEPTH];
  logic [31:0]    q_exc  [DEPTH];
  logic [QPW-1:0] q_wr;
  logic [QPW-1:0] q_rd;
  logic [QCW-1:0] q_count;

  logic           pc_aligned;
  logic           accept;
  logic           ret;
  logic           pop;
  logic           push;
  logic           misalign_push;
  logic [31:0]    push_pc;
  logic [31:0]    push_inst;
  logic [31:0]    push_exc;
  logic [7:0]     credit_used;

  function automatic logic [PW-1:0] pcf_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign inst_wr       = 1'b0;
  assign inst_size     = 2'b10;
  assign inst_wdata    = 32'h0;
  assign inst_addr     = {3'b000, fetch_pc[28:0]};
  assign inst_uncached = fetch_pc[29];

  assign pc_aligned = (fetch_pc[1:0] == 2'b00);
  // Slots already promised to the queue: entries held plus live (non-discarded) requests.
  assign credit_used = 8'(q_count) + 8'(outstanding) - 8'(discard);

  assign inst_req = !rst && !redirect_valid && !halted && pc_aligned &&
                    (outstanding < OW'(MAX_OUTSTANDING)) && (credit_used < 8'(DEPTH));

  assign accept = inst_req && inst_addr_ok;
  assign ret    = inst_data_ok && (outstanding != '0);
  assign out_valid = (q_count != '0);
  assign pop    = out_valid && out_ready;

`ifdef IFETCH_MISALIGN_EXC_EN
  assign misalign_push = !redirect_valid && !halted && !pc_aligned &&
                         (outstanding == '0) && (discard == '0) && (q_count < QCW'(DEPTH));
`else
  assign misalign_push = 1'b0;
`endif

  assign push      = !redirect_valid && ((ret && (discard == '0)) || misalign_push);
  assign push_pc   = misalign_push ? fetch_pc : pcf_mem[pcf_rd];
  assign push_inst = misalign_push ? 32'h0 : inst_rdata;
  assign push_exc  = misalign_push ? EXC_ADEL : 32'h0;

  assign outstanding_next = outstanding + OW'(accept) - OW'(ret);

  assign out_inst        = out_valid ? q_inst[q_rd] : 32'h0;
  assign out_pc          = out_valid ? q_pc[q_rd]   : 32'h0;
  assign out_except_type = out_valid ? q_exc[q_rd]  : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC & PC_MASK;
      outstanding <= '0;
      discard     <= '0;
      halted      <= 1'b0;
      pcf_wr      <= '0;
      pcf_rd      <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      q_count     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (accept) begin
        pcf_wr   <= pcf_inc(pcf_wr);
        fetch_pc <= (fetch_pc + 32'd4) & PC_MASK;
      end
      if (ret) pcf_rd <= pcf_inc(pcf_rd);
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old stream.
        fetch_pc <= redirect_pc & PC_MASK;
        discard  <= outstanding_next;
        halted   <= 1'b0;
        q_wr     <= '0;
        q_rd     <= '0;
        q_count  <= '0;
      end else begin
        if (ret && (discard != '0)) discard <= discard - OW'(1);
        if (push) q_wr <= q_wr + QPW'(1);
        if (pop)  q_rd <= q_rd + QPW'(1);
        q_count <= q_count + QCW'(push) - QCW'(pop);
        if (misalign_push) halted <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pcf_mem[pcf_wr] <= fetch_pc;
    if (push) begin
      q_pc[q_wr]   <= push_pc;
      q_inst[q_wr] <= push_inst;
      q_exc[q_wr]  <= push_exc;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: cycle-stepped bus responder plus a transaction-level
// stream model (epochs per redirect) that predicts every output each cycle.
module tb_ifetch_prefetch;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, inst_uncached;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc, out_except_type;

  ifetch_prefetch #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_uncached(inst_uncached),
    .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_except_type(out_except_type)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] pc; int epoch; int due; } bus_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic [31:0] exc; } ent_t;

  bus_t        bus_q[$];
  ent_t        mq[$];
  logic [31:0] mfpc;
  bit          m_halted;
  int          epoch, cyc, vectors, miscompares, pops;
  logic [31:0] last_pop_pc;
  int          addr_mode, lat_min, lat_max, ready_pct, req_wait;
  bit          drv_redirect;
  logic [31:0] drv_rpc;
  logic [31:0] prev_addr;
  bit          prev_wait;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h3C1D_A5E7;
  endfunction

  function automatic logic [31:0] mask_pc(input logic [31:0] p);
`ifdef IFETCH_MISALIGN_EXC_EN
    return p;
`else
    return p & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic cycle();
    int   cur_pend;
    int   lat;
    int   due;
    bit   dok;
    bit   exp_req;
    bit   misal;
    bus_t b;
    ent_t e;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_rpc;
    out_ready      = ($urandom_range(99) < ready_pct);
    case (addr_mode)
      0:       inst_addr_ok = 1'b1;
      1:       inst_addr_ok = 1'($urandom_range(1));
      default: inst_addr_ok = (req_wait >= 3);
    endcase
    dok = (bus_q.size() > 0) && (bus_q[0].due <= cyc);
    inst_data_ok = dok;
    inst_rdata   = dok ? inst_of(bus_q[0].addr) : $urandom();
    #1;
    cur_pend = 0;
    foreach (bus_q[i]) if (bus_q[i].epoch == epoch) cur_pend++;
    exp_req = !drv_redirect && !m_halted && (mfpc[1:0] == 2'b00) &&
              (bus_q.size() < MAXO) && ((mq.size() + cur_pend) < DEPTH);
    chk("inst_req", 32'(inst_req), 32'(exp_req));
    chk("inst_addr", inst_addr, {3'b000, mfpc[28:0]});
    chk("inst_uncached", 32'(inst_uncached), 32'(mfpc[29]));
    if (prev_wait && !drv_redirect) begin
      chk("hold_req", 32'(inst_req), 32'd1);
      chk("hold_addr", inst_addr, prev_addr);
    end
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_inst", out_inst, mq[0].inst);
      chk("out_except", out_except_type, mq[0].exc);
    end else begin
      chk("empty_pc", out_pc, 32'h0);
      chk("empty_inst", out_inst, 32'h0);
      chk("empty_except", out_except_type, 32'h0);
    end
    prev_wait = inst_req && !inst_addr_ok;
    prev_addr = inst_addr;
    if (addr_mode == 2) req_wait = (inst_req && !inst_addr_ok) ? req_wait + 1 : 0;
`ifdef IFETCH_MISALIGN_EXC_EN
    misal = (mfpc[1:0] != 2'b00) && !m_halted && (bus_q.size() == 0) && (mq.size() < DEPTH);
`else
    misal = 1'b0;
`endif
    if (drv_redirect) begin
      if (dok) void'(bus_q.pop_front());
      mq.delete();
      epoch++;
      mfpc     = mask_pc(drv_rpc);
      m_halted = 1'b0;
    end else begin
      if ((mq.size() != 0) && out_ready) begin
        last_pop_pc = mq[0].pc;
        pops++;
        void'(mq.pop_front());
      end
      if (dok) begin
        b = bus_q.pop_front();
        if (b.epoch == epoch) begin
          e.pc = b.pc; e.inst = inst_of(b.addr); e.exc = 32'h0;
          mq.push_back(e);
        end
      end
      if (misal) begin
        e.pc = mfpc; e.inst = 32'h0; e.exc = 32'h0000_4000;
        mq.push_back(e);
        m_halted = 1'b1;
      end
      if (inst_req && inst_addr_ok) begin
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (bus_q.size() > 0 && due <= bus_q[$].due) due = bus_q[$].due + 1;
        b.addr = inst_addr; b.pc = mfpc; b.epoch = epoch; b.due = due;
        bus_q.push_back(b);
        mfpc = mfpc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    drv_redirect = 1'b1;
    drv_rpc      = pc;
    cycle();
    drv_redirect = 1'b0;
  endtask

  initial begin
    int n;
    int p0;
    rst = 1'b1;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    vectors = 0; miscompares = 0; pops = 0; cyc = 0; epoch = 0;
    addr_mode = 0; lat_min = 1; lat_max = 1; ready_pct = 100; req_wait = 0;
    drv_redirect = 1'b0; drv_rpc = 32'h0; prev_wait = 1'b0; prev_addr = 32'h0;
    mfpc = mask_pc(RPC); m_halted = 1'b0; last_pop_pc = 32'h0;

    @(negedge clk);
    chk("rst_inst_req", 32'(inst_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_except", out_except_type, 32'h0);
    chk("rst_inst_addr", inst_addr, 32'h1FC0_0000);
    chk("rst_uncached", 32'(inst_uncached), 32'd1);
    chk("inst_wr", 32'(inst_wr), 32'd0);
    chk("inst_size", 32'(inst_size), 32'd2);
    chk("inst_wdata", inst_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // One-cycle bus, consumer always ready: one instruction per cycle once warm.
    repeat (5) cycle();
    p0 = pops;
    repeat (20) cycle();
    chk("throughput", 32'(pops - p0), 32'd20);

    // Consumer stalls: queue fills, requests stop; then drains in order.
    ready_pct = 0;
    repeat (12) cycle();
    #1;
    chk("full_req", 32'(inst_req), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);
    ready_pct = 100;
    repeat (12) cycle();

    // Two requests in flight, then redirect: both responses dropped.
    lat_min = 3; lat_max = 3;
    n = 0;
    while (bus_q.size() < 2 && n < 20) begin cycle(); n++; end
    if (bus_q.size() != 2) bound_fail("two_in_flight");
    redirect_to(32'h8000_1000);
    #1;
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_addr", inst_addr, 32'h0000_1000);
    chk("redir_uncached", 32'(inst_uncached), 32'd0);
    p0 = pops; n = 0;
    while (pops == p0 && n < 30) begin cycle(); n++; end
    if (pops == p0) bound_fail("redir_first_pop");
    chk("redir_first_pc", last_pop_pc, 32'h8000_1000);

    // Redirect in the same cycle as a response: that response is dropped too.
    lat_min = 2; lat_max = 2;
    n = 0;
    while (!(bus_q.size() == 2 && bus_q[0].due <= cyc) && n < 30) begin cycle(); n++; end
    if (!(bus_q.size() == 2 && bus_q[0].due <= cyc)) bound_fail("dok_redirect_setup");
    redirect_to(32'hA000_0100);
    #1;
    chk("dok_redir_req", 32'(inst_req), 32'd1);
    chk("dok_redir_addr", inst_addr, 32'h0000_0100);
    p0 = pops; n = 0;
    while (pops == p0 && n < 30) begin cycle(); n++; end
    if (pops == p0) bound_fail("dok_redir_pop");
    chk("dok_redir_first_pc", last_pop_pc, 32'hA000_0100);

    // Bus holds off addr_ok for 3 cycles per request.
    addr_mode = 2; lat_min = 1; lat_max = 2; req_wait = 0;
    repeat (40) cycle();
    addr_mode = 0;

    // Misaligned redirect target.
    ready_pct = 0;
    redirect_to(32'h8000_0002);
    repeat (10) cycle();
    #1;
`ifdef IFETCH_MISALIGN_EXC_EN
    chk("misal_pc", out_pc, 32'h8000_0002);
    chk("misal_except", out_except_type, 32'h0000_4000);
    chk("misal_inst", out_inst, 32'h0);
    chk("misal_req", 32'(inst_req), 32'd0);
`else
    chk("misal_pc", out_pc, 32'h8000_0000);
    chk("misal_except", out_except_type, 32'h0);
`endif
    ready_pct = 100;
    repeat (4) cycle();
    redirect_to(32'h8000_0000);
    repeat (15) cycle();

    // Randomised traffic with occasional redirects, including a wrap-around target.
    addr_mode = 1; lat_min = 1; lat_max = 4; ready_pct = 70;
    repeat (1500) begin
      drv_redirect = ($urandom_range(39) == 0);
      case ($urandom_range(3))
        0:       drv_rpc = $urandom();
        1:       drv_rpc = 32'hFFFF_FFF8;
        default: drv_rpc = $urandom() & 32'hFFFF_FFFC;
      endcase
      cycle();
    end
    drv_redirect = 1'b0;

    // Reset asserted mid-transaction clears everything immediately.
    addr_mode = 0; lat_min = 3; lat_max = 3; ready_pct = 100;
    repeat (3) cycle();
    #2;
    rst = 1'b1;
    inst_data_ok = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_req", 32'(inst_req), 32'd0);
    chk("mid_rst_addr", inst_addr, 32'h1FC0_0000);
    chk("mid_rst_pc", out_pc, 32'h0);
    bus_q.delete(); mq.delete();
    mfpc = mask_pc(RPC); m_halted = 1'b0; epoch++; prev_wait = 1'b0; req_wait = 0;
    @(negedge clk);
    rst = 1'b0;
    lat_min = 1; lat_max = 1;
    repeat (20) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch.md
# ifetch_prefetch

Parametrised instruction-fetch front end with a sequential prefetcher, up to MAX_OUTSTANDING in-flight requests and a DEPTH-entry instruction queue. It sits between the PC/branch logic and the inst sram-like bus. It replaces the single-request fetch stage: the fetch stage stalls only when the queue is empty, not on every fetch. Redirects (branch, exception, eret) flush the queue and silently drain stale in-flight responses.

## Interface
- DEPTH, 4, instruction queue entries; power of 2, 2..16
- MAX_OUTSTANDING, 2, accepted-but-unanswered bus requests; 1..4
- RESET_PC, 32'hBFC0_0000, fetch PC after reset

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- inst_req  out  1  bus request
- inst_wr  out  1  constant 0
- inst_size  out  2  constant 2'b10
- inst_addr  out  32  {3'b0, fetch_pc[28:0]}
- inst_wdata  out  32  constant 0
- inst_uncached  out  1  fetch_pc[29]
- inst_rdata  in  32  returned instruction
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  oldest accepted request returns inst_rdata this cycle
- redirect_valid  in  1  load new fetch PC, flush
- redirect_pc  in  32  new fetch PC
- out_valid  out  1  queue head valid
- out_ready  in  1  consumer takes head
- out_inst  out  32  head instruction; 0 when empty
- out_pc  out  32  head PC; 0 when empty
- out_except_type  out  32  head exception vector; bit 14 = instruction-address misaligned

## Operation
- State: fetch_pc, outstanding counter (0..MAX_OUTSTANDING), discard counter, PC FIFO of accepted requests (MAX_OUTSTANDING deep), output queue of {pc, inst, except} (DEPTH deep), halted flag.
- inst_req = !rst && !redirect_valid && !halted && fetch_pc[1:0]==0 && outstanding < MAX_OUTSTANDING && (queue_count + outstanding - discard) < DEPTH. This credit rule makes queue overflow impossible.
- Accept (inst_req && inst_addr_ok): push fetch_pc to the PC FIFO, outstanding+1, fetch_pc += 4. The addition wraps modulo 2^32.
- Return (inst_data_ok): pop the PC FIFO, outstanding-1.
  - If discard > 0: drop the data, discard-1.
  - Otherwise push {pc, inst_rdata, 0} to the queue.
- inst_data_ok with outstanding==0 is a bus protocol error and is ignored.
- Pop: out_valid && out_ready. A push and a pop in the same cycle keep the count unchanged.
- Redirect (has priority over every other event in the cycle):
  - fetch_pc <= redirect_pc; queue emptied; halted cleared.
  - discard <= outstanding_next, the post-cycle outstanding count including this cycle's return. A response arriving in the redirect cycle is dropped.
  - No request is issued in the redirect cycle.
- Misaligned fetch_pc (configurable, see Configuration): no bus request is issued. Once outstanding==0, discard==0 and the queue is not full, push {fetch_pc, 32'h0, 32'h0000_4000} and set halted. The block remains halted until a redirect.

## Timing
- Reset (asynchronous assert): fetch_pc=RESET_PC, counters 0, queues empty, halted 0. Outputs: inst_req 0, out_valid 0, out_inst 0, out_pc 0, out_except_type 0, inst_addr {3'b0, RESET_PC[28:0]}.
- First inst_req: first clk edge after rst deasserts.
- Latency: inst_data_ok in cycle N -> out_valid/out_inst in cycle N+1 (registered queue; no fall-through).
- Back-to-back: with a 1-cycle bus and MAX_OUTSTANDING ≥ 2, the block sustains one instruction per cycle.
- Redirect in cycle N: out_valid=0 in N+1; the first request to redirect_pc is issued in N+1.
- inst_addr and inst_uncached change only on accept, redirect or reset. They are stable while inst_req is waiting for inst_addr_ok.
- rst asserted mid-transaction: all state clears immediately. The bus is reset with the block, so no stale responses are expected.

## Configuration
- IFETCH_MISALIGN_EXC_EN defined: misaligned fetch_pc handling as described in Operation (exception entry with bit 14 set, then halt).
- Not defined:
  - fetch_pc[1:0] is forced to 00 on reset, redirect and increment.
  - No misaligned entry is ever produced; out_except_type is constant 0 and halted is never set.

## Test plan
- Reset, bus answers addr_ok/data_ok 1 cycle later, out_ready=1 -> out_pc sequence BFC00000, BFC00004, BFC00008… at one per cycle; inst_uncached=1.
- out_ready=0, DEPTH=4 -> exactly 4 entries queued, then inst_req stays 0. Release out_ready -> all 4 entries pop in order, then fetching resumes.
- Two requests in flight, redirect_pc=80001000 -> both responses are dropped; next out_pc=80001000, inst_uncached=0.
- Redirect in the same cycle as inst_data_ok -> that response is not queued; discard count equals the remaining outstanding requests.
- IFETCH_MISALIGN_EXC_EN defined, redirect_pc=80000002 -> no bus request; one entry out_pc=80000002, out_except_type=00004000, out_inst=0. A later redirect to 80000000 resumes fetching.
- Bus delays addr_ok by 3 cycles -> inst_addr stays constant and inst_req stays 1 through the wait; exactly one entry per accepted request is queued.
